// File: rtl/dot11_tx_psdu_framer.sv
// 802.11 legacy TX PSDU framer.
// Builds the 24-bit SIGNAL field, passes the MAC payload through a single
// registered output stage and appends the CRC-32 FCS (reflected, LSB first).
module dot11_tx_psdu_framer (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic        start,
  input  logic [3:0]  pkt_rate,
  input  logic [11:0] pkt_len,
  input  logic [7:0]  byte_in,
  input  logic        byte_in_valid,
  output logic        byte_in_ready,
  output logic [23:0] sig_out,
  output logic        sig_out_strobe,
  output logic [7:0]  byte_out,
  output logic        byte_out_valid,
  input  logic        byte_out_ready,
  output logic [11:0] byte_count,
  output logic        busy,
  output logic        done,
  output logic        err_len
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SIG     = 2'd1,
    ST_PAYLOAD = 2'd2,
    ST_FCS     = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [11:0] len_q, len_d;
  logic [11:0] in_cnt_q, in_cnt_d;
  logic [11:0] byte_count_q, byte_count_d;
  logic [31:0] crc_q, crc_d;
  logic [2:0]  fcs_cnt_q, fcs_cnt_d;
  logic [23:0] sig_q, sig_d;
  logic        strobe_q, strobe_d;
  logic [7:0]  byte_out_q, byte_out_d;
  logic        bov_q, bov_d;
  logic        done_q, done_d;
  logic        err_len_q, err_len_d;

  logic        start_ok, start_bad, stage_free, in_room;
  logic        out_xfer, last_out, in_xfer, last_in, fcs_load;
  logic [31:0] fcs_word;
  logic [7:0]  fcs_byte;

  // One byte of reflected CRC-32 (poly 0xEDB88320), data consumed LSB first.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc ^ {24'h000000, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return c;
  endfunction

  // SIGNAL field: rate, reserved 0, length, even parity over bits 16:0, tail 0.
  function automatic logic [23:0] sig_field(input logic [3:0] rate, input logic [11:0] len);
    logic [16:0] low;
    low = {len, 1'b0, rate};
    return {6'b000000, ^low, low};
  endfunction

  assign start_ok   = (state_q == ST_IDLE) && enable && start && (pkt_len >= 12'd5);
  assign start_bad  = (state_q == ST_IDLE) && enable && start && (pkt_len < 12'd5);
  assign stage_free = enable && (!bov_q || byte_out_ready);
  assign in_room    = in_cnt_q < (len_q - 12'd4);
  // Downstream may drain a pending byte even while frozen.
  assign out_xfer   = bov_q && byte_out_ready;
  assign last_out   = out_xfer && ((byte_count_q + 12'd1) == len_q);
  assign in_xfer    = byte_in_ready && byte_in_valid;
  assign last_in    = in_xfer && ((in_cnt_q + 12'd1) == (len_q - 12'd4));
  assign fcs_word   = ~crc_q;

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    state_d = start_ok ? ST_SIG : ST_IDLE;
      ST_SIG:     state_d = enable ? ST_PAYLOAD : ST_SIG;
      ST_PAYLOAD: state_d = last_in ? ST_FCS : ST_PAYLOAD;
      ST_FCS:     state_d = last_out ? ST_IDLE : ST_FCS;
      default:    state_d = ST_IDLE;
    endcase
  end

  // State-dependent handshake and FCS-load decode.
  always_comb begin
    byte_in_ready = 1'b0;
    fcs_load      = 1'b0;
    case (state_q)
      ST_PAYLOAD: byte_in_ready = stage_free && in_room;
      ST_FCS:     fcs_load      = stage_free && (fcs_cnt_q < 3'd4);
      default: begin
        byte_in_ready = 1'b0;
        fcs_load      = 1'b0;
      end
    endcase
  end

  // Select the FCS byte to emit, low byte of ~CRC first.
  always_comb begin
    case (fcs_cnt_q[1:0])
      2'd0:    fcs_byte = fcs_word[7:0];
      2'd1:    fcs_byte = fcs_word[15:8];
      2'd2:    fcs_byte = fcs_word[23:16];
      2'd3:    fcs_byte = fcs_word[31:24];
      default: fcs_byte = 8'h00;
    endcase
  end

  // Datapath next-state: packet setup, output stage, CRC and counters.
  always_comb begin
    len_d        = len_q;
    in_cnt_d     = in_cnt_q;
    byte_count_d = byte_count_q;
    crc_d        = crc_q;
    fcs_cnt_d    = fcs_cnt_q;
    sig_d        = sig_q;
    strobe_d     = 1'b0;
    byte_out_d   = byte_out_q;
    bov_d        = bov_q;
    done_d       = last_out;
    err_len_d    = start_bad;
    if (start_ok) begin
      len_d        = pkt_len;
      in_cnt_d     = 12'd0;
      byte_count_d = 12'd0;
      crc_d        = 32'hFFFFFFFF;
      fcs_cnt_d    = 3'd0;
      sig_d        = sig_field(pkt_rate, pkt_len);
      strobe_d     = 1'b1;
    end else begin
      strobe_d     = 1'b0;
    end
    if (out_xfer) begin
      bov_d        = 1'b0;
      byte_count_d = byte_count_q + 12'd1;
    end else begin
      bov_d        = bov_q;
    end
    // A reload in the same cycle as a drain keeps the stage full.
    if (in_xfer) begin
      byte_out_d = byte_in;
      bov_d      = 1'b1;
      crc_d      = crc32_byte(crc_q, byte_in);
      in_cnt_d   = in_cnt_q + 12'd1;
    end else if (fcs_load) begin
      byte_out_d = fcs_byte;
      bov_d      = 1'b1;
      fcs_cnt_d  = fcs_cnt_q + 3'd1;
    end else begin
      byte_out_d = byte_out_q;
    end
  end

  // Datapath registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      len_q        <= 12'd0;
      in_cnt_q     <= 12'd0;
      byte_count_q <= 12'd0;
      crc_q        <= 32'hFFFFFFFF;
      fcs_cnt_q    <= 3'd0;
      sig_q        <= 24'd0;
      strobe_q     <= 1'b0;
      byte_out_q   <= 8'd0;
      bov_q        <= 1'b0;
      done_q       <= 1'b0;
      err_len_q    <= 1'b0;
    end else begin
      len_q        <= len_d;
      in_cnt_q     <= in_cnt_d;
      byte_count_q <= byte_count_d;
      crc_q        <= crc_d;
      fcs_cnt_q    <= fcs_cnt_d;
      sig_q        <= sig_d;
      strobe_q     <= strobe_d;
      byte_out_q   <= byte_out_d;
      bov_q        <= bov_d;
      done_q       <= done_d;
      err_len_q    <= err_len_d;
    end
  end

  assign sig_out        = sig_q;
  assign sig_out_strobe = strobe_q;
  assign byte_out       = byte_out_q;
  assign byte_out_valid = bov_q;
  assign byte_count     = byte_count_q;
  assign busy           = (state_q != ST_IDLE);
  assign done           = done_q;
  assign err_len        = err_len_q;

endmodule

// File: tb/tb_dot11_tx_psdu_framer.sv
// Self-checking bench for dot11_tx_psdu_framer: randomized handshakes checked
// against a byte-queue reference model (payload followed by ~CRC-32, LSB first).
module tb_dot11_tx_psdu_framer;

  logic        clock = 1'b0;
  logic        reset;
  logic        enable;
  logic        start;
  logic [3:0]  pkt_rate;
  logic [11:0] pkt_len;
  logic [7:0]  byte_in;
  logic        byte_in_valid;
  logic        byte_in_ready;
  logic [23:0] sig_out;
  logic        sig_out_strobe;
  logic [7:0]  byte_out;
  logic        byte_out_valid;
  logic        byte_out_ready;
  logic [11:0] byte_count;
  logic        busy;
  logic        done;
  logic        err_len;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] pay_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int         done_cyc;

  dot11_tx_psdu_framer dut (
    .clock(clock), .reset(reset), .enable(enable), .start(start),
    .pkt_rate(pkt_rate), .pkt_len(pkt_len), .byte_in(byte_in),
    .byte_in_valid(byte_in_valid), .byte_in_ready(byte_in_ready),
    .sig_out(sig_out), .sig_out_strobe(sig_out_strobe), .byte_out(byte_out),
    .byte_out_valid(byte_out_valid), .byte_out_ready(byte_out_ready),
    .byte_count(byte_count), .busy(busy), .done(done), .err_len(err_len)
  );

  always #5 clock = ~clock;

  // Reference CRC-32 over the payload queue, bit-serial LSB first.
  function automatic logic [31:0] model_crc();
    logic [31:0] crc;
    logic        fb;
    crc = 32'hFFFFFFFF;
    foreach (pay_q[k]) begin
      for (int b = 0; b < 8; b++) begin
        fb  = pay_q[k][b] ^ crc[0];
        crc = {1'b0, crc[31:1]};
        if (fb) crc = crc ^ 32'hEDB88320;
      end
    end
    return crc;
  endfunction

  // Expected PSDU: payload then the four bytes of ~CRC, low byte first.
  function automatic void build_expected();
    logic [31:0] fcs;
    fcs = ~model_crc();
    exp_q = {};
    foreach (pay_q[k]) exp_q.push_back(pay_q[k]);
    for (int i = 0; i < 4; i++) exp_q.push_back(8'((fcs >> (8 * i)) & 32'hFF));
  endfunction

  function automatic logic [23:0] model_sig(input logic [3:0] rate, input logic [11:0] len);
    logic par;
    par = ($countones(rate) + $countones(len)) % 2 == 1;
    return (24'(par) << 17) | (24'(len) << 5) | 24'(rate);
  endfunction

  function automatic void fill_payload(input int n);
    pay_q = {};
    for (int i = 0; i < n; i++) pay_q.push_back(8'($urandom_range(0, 255)));
  endfunction

  task automatic idle_inputs();
    start = 1'b0; enable = 1'b1; pkt_rate = 4'd0; pkt_len = 12'd0;
    byte_in = 8'd0; byte_in_valid = 1'b0; byte_out_ready = 1'b1;
  endtask

  // Pulse start and check the SIGNAL strobe one cycle later.
  task automatic start_pkt(input logic [3:0] rate, input logic [11:0] len);
    @(posedge clock); #1;
    start = 1'b1; pkt_rate = rate; pkt_len = len;
    @(posedge clock); #1;
    start = 1'b0;
    n_vec++;
    if (sig_out_strobe !== 1'b1 || sig_out !== model_sig(rate, len) || busy !== 1'b1) begin
      n_err++;
      $display("FAIL sig_strobe: got strobe=%b sig=%h busy=%b, expected strobe=1 sig=%h busy=1",
               sig_out_strobe, sig_out, busy, model_sig(rate, len));
    end
  endtask

  // Cycle-by-cycle driver/monitor for one packet; optionally injects a start,
  // freezes with enable=0, or stops early after abort_after accepted bytes.
  task automatic run_pkt(input logic [11:0] len, input bit rnd_ready, input bit rnd_valid,
                         input int inject_at, input int freeze_at, input int abort_after);
    int   in_idx = 0, dones = 0, strobes = 0, post = 0, freeze_left = 0;
    bit   freeze_done = 1'b0, prev_v = 1'b0, prev_r = 1'b1;
    logic [7:0] prev_b = 8'd0;
    got_q = {};
    done_cyc = -1;
    for (int cyc = 0; cyc < 3000 && post < 3; cyc++) begin
      @(posedge clock); #1;
      start   = (cyc == inject_at);
      pkt_len = (cyc == inject_at) ? 12'd200 : len;
      if (freeze_left > 0) begin
        enable = 1'b0; byte_out_ready = 1'b0; freeze_left--;
      end else begin
        enable = 1'b1;
        byte_out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      byte_in_valid = (in_idx < pay_q.size()) && (rnd_valid ? 1'($urandom_range(0, 1)) : 1'b1);
      byte_in = (in_idx < pay_q.size()) ? pay_q[in_idx] : 8'h00;
      @(negedge clock);
      if (prev_v && !prev_r) begin
        n_vec++;
        if (byte_out_valid !== 1'b1 || byte_out !== prev_b) begin
          n_err++;
          $display("FAIL stall_hold: got valid=%b byte=%h, expected valid=1 byte=%h",
                   byte_out_valid, byte_out, prev_b);
        end
      end
      if (!enable) begin
        n_vec++;
        if (byte_in_ready !== 1'b0 || busy !== 1'b1) begin
          n_err++;
          $display("FAIL freeze: got ready=%b busy=%b, expected ready=0 busy=1", byte_in_ready, busy);
        end
      end
      if (byte_out_valid && byte_out_ready) got_q.push_back(byte_out);
      if (byte_in_valid && byte_in_ready) in_idx++;
      if (sig_out_strobe) strobes++;
      if (done) begin
        dones++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (dones > 0) post++;
      prev_v = byte_out_valid; prev_r = byte_out_ready; prev_b = byte_out;
      if (freeze_at >= 0 && !freeze_done && in_idx == freeze_at) begin
        freeze_left = 10; freeze_done = 1'b1;
      end
      if (abort_after >= 0 && in_idx == abort_after) return;
    end
    start = 1'b0; byte_in_valid = 1'b0; enable = 1'b1; byte_out_ready = 1'b1;
    n_vec++;
    if (dones !== 1) begin
      n_err++;
      $display("FAIL done_count: got %0d pulses, expected 1", dones);
    end
    n_vec++;
    if (got_q.size() !== exp_q.size()) begin
      n_err++;
      $display("FAIL out_len: got %0d bytes, expected %0d", got_q.size(), exp_q.size());
    end else begin
      int bad = -1;
      foreach (exp_q[k]) if (bad < 0 && got_q[k] !== exp_q[k]) bad = k;
      if (bad >= 0) begin
        n_err++;
        $display("FAIL out_bytes: byte %0d got %h expected %h", bad, got_q[bad], exp_q[bad]);
      end
    end
    n_vec++;
    if (byte_count !== len || busy !== 1'b0 || strobes !== 0) begin
      n_err++;
      $display("FAIL end_state: got count=%0d busy=%b strobes=%0d, expected count=%0d busy=0 strobes=0",
               byte_count, busy, strobes, len);
    end
  endtask

  task automatic check_all_zero(input string tag);
    n_vec++;
    if (sig_out !== 24'd0 || sig_out_strobe !== 1'b0 || byte_out !== 8'd0 ||
        byte_out_valid !== 1'b0 || byte_in_ready !== 1'b0 || byte_count !== 12'd0 ||
        busy !== 1'b0 || done !== 1'b0 || err_len !== 1'b0) begin
      n_err++;
      $display("FAIL %s: got sig=%h stb=%b bo=%h bov=%b bir=%b cnt=%0d busy=%b done=%b err=%b, expected all 0",
               tag, sig_out, sig_out_strobe, byte_out, byte_out_valid, byte_in_ready,
               byte_count, busy, done, err_len);
    end
  endtask

  task automatic load_ascii();
    pay_q = {};
    for (int i = 0; i < 9; i++) pay_q.push_back(8'h31 + 8'(i));
    build_expected();
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    #1;
    check_all_zero("reset_state");
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
  endtask

  task automatic test_known_vector();
    logic [7:0] fcs_ref[4];
    fcs_ref = '{8'h26, 8'h39, 8'hF4, 8'hCB};
    load_ascii();
    start_pkt(4'b1101, 12'd13);
    n_vec++;
    if (sig_out !== 24'h0001AD) begin
      n_err++;
      $display("FAIL sig_const: got %h expected 0001ad", sig_out);
    end
    run_pkt(12'd13, 1'b0, 1'b0, -1, -1, -1);
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if (got_q.size() < 13 || got_q[9 + i] !== fcs_ref[i]) begin
        n_err++;
        $display("FAIL fcs_const%0d: got %h expected %h", i,
                 (got_q.size() > 9 + i) ? got_q[9 + i] : 8'hxx, fcs_ref[i]);
      end
    end
    n_vec++;
    if (done_cyc !== 14) begin
      n_err++;
      $display("FAIL throughput: done at cycle %0d expected 14", done_cyc);
    end
  endtask

  task automatic test_stall();
    load_ascii();
    start_pkt(4'b1101, 12'd13);
    run_pkt(12'd13, 1'b1, 1'b0, -1, -1, -1);
  endtask

  task automatic test_err_len();
    logic [7:0] fcs_ref[4];
    fcs_ref = '{8'h8D, 8'hEF, 8'h02, 8'hD2};
    @(posedge clock); #1;
    start = 1'b1; pkt_len = 12'd4; pkt_rate = 4'b1011;
    @(posedge clock); #1;
    start = 1'b0;
    n_vec++;
    if (err_len !== 1'b1 || sig_out_strobe !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL err_len_pulse: got err=%b stb=%b busy=%b, expected err=1 stb=0 busy=0",
               err_len, sig_out_strobe, busy);
    end
    @(posedge clock); #1;
    n_vec++;
    if (err_len !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL err_len_once: got err=%b busy=%b, expected 0 0", err_len, busy);
    end
    pay_q = {8'h00};
    build_expected();
    start_pkt(4'b1011, 12'd5);
    run_pkt(12'd5, 1'b0, 1'b0, -1, -1, -1);
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if (got_q.size() < 5 || got_q[1 + i] !== fcs_ref[i]) begin
        n_err++;
        $display("FAIL min_fcs%0d: got %h expected %h", i,
                 (got_q.size() > 1 + i) ? got_q[1 + i] : 8'hxx, fcs_ref[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    load_ascii();
    start_pkt(4'b1101, 12'd13);
    run_pkt(12'd13, 1'b0, 1'b0, -1, -1, 3);
    #2 reset = 1'b1;
    #1;
    check_all_zero("reset_mid");
    idle_inputs();
    @(posedge clock); #1;
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check_all_zero("reset_no_resume");
    load_ascii();
    start_pkt(4'b1101, 12'd13);
    run_pkt(12'd13, 1'b0, 1'b0, -1, -1, -1);
  endtask

  task automatic test_ignore_start_and_freeze();
    load_ascii();
    start_pkt(4'b1101, 12'd13);
    run_pkt(12'd13, 1'b0, 1'b0, 2, 5, -1);
  endtask

  task automatic test_random();
    for (int p = 0; p < 6; p++) begin
      logic [3:0]  rate;
      logic [11:0] len;
      rate = 4'($urandom_range(0, 15));
      len  = 12'($urandom_range(5, 48));
      fill_payload(int'(len) - 4);
      build_expected();
      start_pkt(rate, len);
      run_pkt(len, 1'b1, 1'b1, -1, (p % 2 == 0) ? int'(len) / 3 : -1, -1);
    end
  endtask

  task automatic test_back_to_back();
    for (int p = 0; p < 3; p++) begin
      logic [11:0] len;
      len = 12'($urandom_range(5, 20));
      fill_payload(int'(len) - 4);
      build_expected();
      start_pkt(4'b0101, len);
      run_pkt(len, 1'b0, 1'b0, -1, -1, -1);
      n_vec++;
      if (done_cyc !== int'(len) + 1) begin
        n_err++;
        $display("FAIL b2b_throughput: done at cycle %0d expected %0d", done_cyc, int'(len) + 1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_known_vector();
    test_stall();
    test_err_len();
    test_reset_mid();
    test_ignore_start_and_freeze();
    test_random();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
